ahb_single_master: RTL and testbench
====================================

// Module: ahb_single_master
// PURPOSE
//  AHB-Lite initiator that converts a simple valid/ready register-request port into AHB single transfers.
//  Sits between an internal requester (debug port, boot loader, test sequencer) and the AHB fabric.
//  Drives slaves such as ahb2regbus-fronted peripherals (core timer etc.).
//  One outstanding transfer at a time, 32-bit word accesses only; reports read data and bus errors.
// PARAMETERS
//  ADDR_WIDTH      32   HADDR / req_addr width
//  DATA_WIDTH      32   HWDATA / HRDATA / req_wdata width
//  TIMEOUT_CYCLES  256  HREADY-low cycles before abort (used only with AHB_MST_TIMEOUT_EN)
// PORTS
//  HCLK         in   1           clock; all logic on rising edge
//  HRESETn      in   1           asynchronous active-low reset
//  req_valid    in   1           request present
//  req_ready    out  1           request accepted when req_valid & req_ready
//  req_addr     in   ADDR_WIDTH  byte address, must be word aligned
//  req_wr1_rd0  in   1           1 = write, 0 = read
//  req_wdata    in   DATA_WIDTH  write data
//  rsp_valid    out  1           one-cycle completion pulse
//  rsp_rdata    out  DATA_WIDTH  read data, valid with rsp_valid on reads (0 on writes/errors)
//  rsp_err      out  1           completion had ERROR/misalign/timeout, qualified by rsp_valid
//  HADDR        out  ADDR_WIDTH  AHB address
//  HTRANS       out  2           2'b00 IDLE / 2'b10 NONSEQ only
//  HWRITE       out  1           AHB write
//  HSIZE        out  3           fixed 3'b010 (word)
//  HBURST       out  3           fixed 3'b000 (SINGLE)
//  HWDATA       out  DATA_WIDTH  AHB write data
//  HREADY       in   1           transfer-complete from slave/mux
//  HRESP        in   2           2'b00 OKAY, 2'b01 ERROR
//  HRDATA       in   DATA_WIDTH  AHB read data
// BEHAVIOUR
//  Reset (async, HRESETn=0): state IDLE; req_ready=0 during reset then 1; rsp_valid=0, rsp_err=0,
//   rsp_rdata=0, HADDR=0, HTRANS=2'b00, HWRITE=0, HWDATA=0; all outputs registered.
//   Reset mid-transfer drops HTRANS to IDLE at once, no response issued.
//  FSM states: IDLE, ADDR, DATA.
//   IDLE: req_ready=1. On accept with req_addr[1:0]==0: load HADDR/HWRITE, HTRANS=NONSEQ, latch
//    wdata -> ADDR. On accept with req_addr[1:0]!=0: no bus activity; next cycle rsp_valid=1,
//    rsp_err=1; stay IDLE.
//   ADDR: hold HADDR/HTRANS/HWRITE while HREADY=0. On HREADY=1: HTRANS=IDLE, HWDATA=latched
//    wdata (writes) -> DATA.
//   DATA: hold HWDATA while HREADY=0. On HREADY=1: capture HRDATA (reads), rsp_err=(HRESP==ERROR),
//    next cycle rsp_valid=1 -> IDLE.
//  ERROR response: slave's first ERROR cycle (HREADY=0) is ignored; completion is taken only at
//   HREADY=1. HRESP sampled only in DATA with HREADY=1.
//  req_ready=0 in ADDR and DATA; no pipelining, single outstanding transfer.
//  Minimum latency (zero-wait slave): accept edge T, address phase T+1, data phase T+2,
//   rsp_valid in T+3; new request may be accepted in the same cycle rsp_valid is high.
//  rsp_valid is a 1-cycle pulse, no backpressure; rsp_rdata/rsp_err hold until next completion.
// CONFIGURATION
//  AHB_MST_TIMEOUT_EN defined: counter (width clog2(TIMEOUT_CYCLES)+1) increments on each
//   HREADY=0 cycle in ADDR/DATA and clears on state change. When it reaches TIMEOUT_CYCLES:
//   HTRANS=IDLE, next cycle rsp_valid=1 with rsp_err=1, state -> IDLE.
//  AHB_MST_TIMEOUT_EN undefined: no counter; master waits indefinitely on HREADY.
// TESTING
//  Zero-wait read of 0x0000_4000, HRDATA=0x1234_5678 -> NONSEQ for 1 cycle; rsp_valid at T+3;
//   rsp_rdata=0x1234_5678, rsp_err=0.
//  Write 0x0000_4004 data 0xA5A5_0001, 2 wait states in data phase -> HWDATA stable 3 cycles;
//   rsp_valid at T+5, rsp_err=0.
//  Read with 2-cycle ERROR response (HREADY 0/1, HRESP 01/01) -> rsp_valid once, rsp_err=1,
//   rsp_rdata=0.
//  Misaligned req_addr=0x0000_4002 -> HTRANS stays 00 throughout; rsp_valid+rsp_err at T+1.
//  HREADY=0 for 3 cycles during address phase -> HADDR/HTRANS held 4 cycles; one transfer only.
//  With AHB_MST_TIMEOUT_EN, TIMEOUT_CYCLES=8, HREADY stuck 0 -> rsp_err=1 after 8 stall cycles,
//   req_ready=1. HRESETn pulsed mid-DATA -> HTRANS=00, rsp_valid never asserted.

Source files
------------

// File: rtl/ahb_single_master.sv
// AHB-Lite initiator: one valid/ready register request -> one AHB SINGLE word transfer; optional abort via `AHB_MST_TIMEOUT_EN.
// Latency: accept edge T, address phase T+1, data phase T+2, rsp_valid high in cycle T+3 (+1 per HREADY-low cycle).
// Backpressure: req_ready low while a transfer is outstanding; the response pulse cannot be stalled.
module ahb_single_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_wr1_rd0,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    input  logic [1:0]            HRESP,
    input  logic [DATA_WIDTH-1:0] HRDATA
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] RESP_ERROR   = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic [ADDR_WIDTH-1:0] r_haddr;
    logic [1:0]            r_htrans;
    logic                  r_hwrite;
    logic [DATA_WIDTH-1:0] r_hwdata;
    logic [DATA_WIDTH-1:0] r_wdata_lat;

    logic                  w_req_ready_nxt;
    logic                  w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0] w_rsp_rdata_nxt;
    logic                  w_rsp_err_nxt;
    logic [ADDR_WIDTH-1:0] w_haddr_nxt;
    logic [1:0]            w_htrans_nxt;
    logic                  w_hwrite_nxt;
    logic [DATA_WIDTH-1:0] w_hwdata_nxt;
    logic [DATA_WIDTH-1:0] w_wdata_lat_nxt;

    logic                  w_accept;
    logic                  w_aligned;
    logic                  w_timeout;

    assign w_accept  = req_valid & r_req_ready;
    assign w_aligned = (req_addr[1:0] == 2'b00);

`ifdef AHB_MST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] r_tmo_cnt;

    // The stall that would bring the count to TIMEOUT_CYCLES aborts on that same edge.
    assign w_timeout = (r_state != ST_IDLE) && !HREADY &&
                       (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_tmo_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_tmo_cnt <= '0;
        end else if ((r_state != ST_IDLE) && !HREADY) begin
            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_haddr_nxt     = r_haddr;
        w_htrans_nxt    = r_htrans;
        w_hwrite_nxt    = r_hwrite;
        w_hwdata_nxt    = r_hwdata;
        w_wdata_lat_nxt = r_wdata_lat;

        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_aligned) begin
                        w_haddr_nxt     = req_addr;
                        w_hwrite_nxt    = req_wr1_rd0;
                        w_htrans_nxt    = TRANS_NONSEQ;
                        w_wdata_lat_nxt = req_wdata;
                        w_state_nxt     = ST_ADDR;
                    end else begin
                        // Misaligned: answer locally, the bus never sees it.
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                        w_rsp_rdata_nxt = '0;
                    end
                end
            end
            ST_ADDR: begin
                if (w_timeout) begin
                    w_htrans_nxt    = TRANS_IDLE;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_state_nxt     = ST_IDLE;
                end else if (HREADY) begin
                    w_htrans_nxt = TRANS_IDLE;
                    if (r_hwrite) begin
                        w_hwdata_nxt = r_wdata_lat;
                    end
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_timeout) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_state_nxt     = ST_IDLE;
                end else if (HREADY) begin
                    // The first ERROR cycle arrives with HREADY low and is deliberately not sampled.
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = (HRESP == RESP_ERROR);
                    w_rsp_rdata_nxt = (!r_hwrite && (HRESP != RESP_ERROR)) ? HRDATA : '0;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_htrans_nxt = TRANS_IDLE;
                w_state_nxt  = ST_IDLE;
            end
        endcase

        w_req_ready_nxt = (w_state_nxt == ST_IDLE);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_haddr     <= '0;
            r_htrans    <= TRANS_IDLE;
            r_hwrite    <= 1'b0;
            r_hwdata    <= '0;
            r_wdata_lat <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_haddr     <= w_haddr_nxt;
            r_htrans    <= w_htrans_nxt;
            r_hwrite    <= w_hwrite_nxt;
            r_hwdata    <= w_hwdata_nxt;
            r_wdata_lat <= w_wdata_lat_nxt;
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign HADDR     = r_haddr;
    assign HTRANS    = r_htrans;
    assign HWRITE    = r_hwrite;
    assign HWDATA    = r_hwdata;
    assign HSIZE     = 3'b010;
    assign HBURST    = 3'b000;

endmodule

// File: tb/tb_ahb_single_master.sv
// Bench for ahb_single_master: vector table, randomized transfers against a transaction-level model, reset/timeout sequences.
module tb_ahb_single_master;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wr1_rd0;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;

    ahb_single_master #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_wr1_rd0 (req_wr1_rd0),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HSIZE       (HSIZE),
        .HBURST      (HBURST),
        .HWDATA      (HWDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .HRDATA      (HRDATA)
    );

    always #5 HCLK = ~HCLK;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] prev_rdata = '0;
    logic        prev_err   = 1'b0;

    // Slave memory is written only from what appears on the bus; the model memory only from requests.
    logic [31:0] slv_mem [logic [31:0]];
    logic [31:0] mdl_mem [logic [31:0]];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        return mdl_mem.exists(a) ? mdl_mem[a] : init_val(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Starts at a negedge; returns at the negedge where the response was seen (or the budget ran out).
    task automatic run_txn(input string tag, input logic [31:0] addr, input logic wr,
                           input logic [31:0] wdata, input int aw, input int dw, input logic err,
                           input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata);
        int          got_lat    = 0;
        int          nonseq_cnt = 0;
        int          aw_left    = aw;
        int          dw_left    = dw;
        logic        sl_phase   = 1'b0;
        logic [31:0] sl_addr    = 32'hDEAD_BEEF;
        logic        sl_wr      = ~wr;
        logic        hwdata_ok  = 1'b1;
        logic [31:0] got_rdata  = 'x;
        logic        got_err    = 1'bx;
        logic        mis;
        mis = (addr[1:0] != 2'b00);

        chk({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid   = 1'b1;
        req_addr    = addr;
        req_wr1_rd0 = wr;
        req_wdata   = wdata;
        HREADY      = 1'b1;
        HRESP       = 2'b00;
        for (int n = 1; n <= exp_lat + 20; n++) begin
            @(negedge HCLK);
            req_valid   = 1'b0;
            req_addr    = $urandom;
            req_wdata   = $urandom;
            req_wr1_rd0 = 1'($urandom_range(0, 1));
            if (HTRANS == 2'b10) nonseq_cnt++;
            if (n == 1 && !mis) chk({tag, " rsp hold"}, {rsp_err, rsp_rdata[30:0]}, {prev_err, prev_rdata[30:0]});
            if (rsp_valid) begin
                got_lat   = n;
                got_rdata = rsp_rdata;
                got_err   = rsp_err;
                break;
            end
            if (!sl_phase) begin
                HRESP  = 2'b00;
                HRDATA = $urandom;
                if (HTRANS == 2'b10) begin
                    if (aw_left > 0) begin
                        HREADY = 1'b0;
                        aw_left--;
                    end else begin
                        HREADY   = 1'b1;
                        sl_addr  = HADDR;
                        sl_wr    = HWRITE;
                        sl_phase = 1'b1;
                    end
                end else begin
                    HREADY = 1'b1;
                end
            end else begin
                if (wr && HWDATA !== wdata) hwdata_ok = 1'b0;
                if (dw_left > 0) begin
                    HREADY = 1'b0;
                    HRESP  = (err && dw_left == 1) ? 2'b01 : 2'b00;
                    HRDATA = $urandom;
                    dw_left--;
                end else begin
                    HREADY = 1'b1;
                    HRESP  = err ? 2'b01 : 2'b00;
                    HRDATA = (!sl_wr && !err) ? slv_rd(sl_addr) : $urandom;
                    if (sl_wr && !err) slv_mem[sl_addr] = HWDATA;
                    sl_phase = 1'b0;
                end
            end
        end
        HREADY = 1'b1;
        HRESP  = 2'b00;

        chk({tag, " latency"}, got_lat, exp_lat);
        chk({tag, " rsp_err"}, {31'd0, got_err}, {31'd0, exp_err});
        chk({tag, " rsp_rdata"}, got_rdata, exp_rdata);
        chk({tag, " nonseq cycles"}, nonseq_cnt, mis ? 0 : 1 + aw);
        if (!mis) begin
            chk({tag, " HADDR"}, sl_addr, addr);
            chk({tag, " HWRITE"}, {31'd0, sl_wr}, {31'd0, wr});
        end
        if (!mis && wr) chk({tag, " HWDATA stable"}, {31'd0, hwdata_ok}, 32'd1);
        prev_rdata = exp_rdata;
        prev_err   = exp_err;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          aw;
        int          dw;
        logic        err;
        int          lat;
        logic        e_err;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t        vt [12];
    logic [31:0] r_addr;
    logic        r_wr;
    logic [31:0] r_wdata;
    int          r_aw;
    int          r_dw;
    logic        r_err;
    logic        r_mis;
    int          bad;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin
        //        addr          wr    wdata          aw dw err   lat err   rdata
        vt[0]  = '{32'h0000_4000, 1'b1, 32'h1234_5678, 0, 0, 1'b0, 3, 1'b0, 32'h0};
        vt[1]  = '{32'h0000_4000, 1'b0, 32'h0,         0, 0, 1'b0, 3, 1'b0, 32'h1234_5678};
        vt[2]  = '{32'h0000_4004, 1'b1, 32'hA5A5_0001, 0, 2, 1'b0, 5, 1'b0, 32'h0};
        vt[3]  = '{32'h0000_4004, 1'b0, 32'h0,         3, 0, 1'b0, 6, 1'b0, 32'hA5A5_0001};
        vt[4]  = '{32'h0000_4008, 1'b0, 32'h0,         0, 1, 1'b1, 4, 1'b1, 32'h0};
        vt[5]  = '{32'h0000_4002, 1'b0, 32'h0,         0, 0, 1'b0, 1, 1'b1, 32'h0};
        vt[6]  = '{32'h0000_4005, 1'b1, 32'hFFFF_FFFF, 0, 0, 1'b0, 1, 1'b1, 32'h0};
        vt[7]  = '{32'h0000_4008, 1'b1, 32'hFFFF_0000, 1, 1, 1'b1, 5, 1'b1, 32'h0};
        vt[8]  = '{32'h0000_4008, 1'b0, 32'h0,         0, 0, 1'b0, 3, 1'b0, 32'h5A5A_4008};
        vt[9]  = '{32'h0000_400C, 1'b1, 32'h0000_0000, 2, 3, 1'b0, 8, 1'b0, 32'h0};
        vt[10] = '{32'h0000_400C, 1'b0, 32'h0,         0, 1, 1'b0, 4, 1'b0, 32'h0};
        vt[11] = '{32'h0000_4004, 1'b0, 32'h0,         1, 1, 1'b0, 5, 1'b0, 32'hA5A5_0001};

        HRESETn     = 1'b0;
        req_valid   = 1'b0;
        req_addr    = '0;
        req_wr1_rd0 = 1'b0;
        req_wdata   = '0;
        HREADY      = 1'b1;
        HRESP       = 2'b00;
        HRDATA      = '0;

        repeat (2) @(negedge HCLK);
        chk("reset req_ready", {31'd0, req_ready}, 32'd0);
        chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset HADDR", HADDR, 32'd0);
        chk("reset HTRANS", {30'd0, HTRANS}, 32'd0);
        chk("reset HWRITE", {31'd0, HWRITE}, 32'd0);
        chk("reset HWDATA", HWDATA, 32'd0);
        chk("HSIZE", {29'd0, HSIZE}, 32'd2);
        chk("HBURST", {29'd0, HBURST}, 32'd0);
        HRESETn = 1'b1;
        @(negedge HCLK);

        for (int i = 0; i < 12; i++) begin
            run_txn($sformatf("vec%0d", i), vt[i].addr, vt[i].wr, vt[i].wdata, vt[i].aw, vt[i].dw,
                    vt[i].err, vt[i].lat, vt[i].e_err, vt[i].e_rdata);
        end

        for (int i = 0; i < 60; i++) begin
            r_addr = 32'h8000_0000 | ($urandom_range(0, 15) << 2);
            if ($urandom_range(0, 7) == 0) r_addr[1:0] = 2'($urandom_range(1, 3));
            r_wr    = 1'($urandom_range(0, 1));
            r_wdata = $urandom;
            r_aw    = $urandom_range(0, 3);
            r_dw    = $urandom_range(0, 3);
            r_err   = ($urandom_range(0, 5) == 0);
            if (r_err && r_dw == 0) r_dw = 1;
            r_mis = (r_addr[1:0] != 2'b00);
            run_txn($sformatf("rnd%0d", i), r_addr, r_wr, r_wdata, r_aw, r_dw, r_err,
                    r_mis ? 1 : 3 + r_aw + r_dw,
                    r_mis | r_err,
                    (r_mis | r_err | r_wr) ? 32'h0 : mdl_rd(r_addr));
            if (!r_mis && !r_err && r_wr) mdl_mem[r_addr] = r_wdata;
        end

        // Reset while the address phase is stalled.
        chk("rstA req_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_addr = 32'h0000_4020; req_wr1_rd0 = 1'b0; req_wdata = '0;
        @(negedge HCLK);
        req_valid = 1'b0;
        HREADY    = 1'b0;
        chk("rstA HTRANS nonseq", {30'd0, HTRANS}, 32'd2);
        @(negedge HCLK);
        chk("rstA HTRANS held", {30'd0, HTRANS}, 32'd2);
        #2 HRESETn = 1'b0;
        #1;
        chk("rstA HTRANS idle", {30'd0, HTRANS}, 32'd0);
        chk("rstA HADDR", HADDR, 32'd0);
        chk("rstA req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        HREADY  = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge HCLK);
            if (rsp_valid || HTRANS != 2'b00) bad++;
        end
        chk("rstA no response", bad, 0);

        // Reset while the data phase is stalled with an ERROR response pending.
        req_valid = 1'b1; req_addr = 32'h0000_4024; req_wr1_rd0 = 1'b1; req_wdata = 32'h0BAD_F00D;
        @(negedge HCLK);
        req_valid = 1'b0;
        HREADY    = 1'b1;
        @(negedge HCLK);
        chk("rstD HWDATA", HWDATA, 32'h0BAD_F00D);
        HREADY = 1'b0;
        HRESP  = 2'b01;
        @(negedge HCLK);
        #2 HRESETn = 1'b0;
        #1;
        chk("rstD HWDATA cleared", HWDATA, 32'd0);
        chk("rstD HTRANS", {30'd0, HTRANS}, 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        HREADY  = 1'b1;
        HRESP   = 2'b00;
        bad = 0;
        repeat (6) begin
            @(negedge HCLK);
            if (rsp_valid || HTRANS != 2'b00) bad++;
        end
        chk("rstD no response", bad, 0);
        prev_rdata = '0;
        prev_err   = 1'b0;

`ifdef AHB_MST_TIMEOUT_EN
        run_txn("timeout", 32'h0000_4030, 1'b0, 32'h0, 0, 1000, 1'b0, 10, 1'b1, 32'h0);
        chk("timeout req_ready", {31'd0, req_ready}, 32'd1);
`endif

        run_txn("final", 32'h0000_4000, 1'b0, 32'h0, 0, 0, 1'b0, 3, 1'b0, 32'h1234_5678);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
